// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-compatible interrupt sequencer.
package pic_pkg;

  localparam int NUM_IR   = 8;
  localparam int LTIM_BIT = 3;
  localparam int AEOI_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    WAIT2,
    ACK2
  } seq_state_e;

  typedef enum logic [2:0] {
    ROT_AEOI_CLR = 3'b000,
    EOI_NS       = 3'b001,
    NOP          = 3'b010,
    EOI_SP       = 3'b011,
    ROT_AEOI_SET = 3'b100,
    ROT_NS       = 3'b101,
    SET_PRI      = 3'b110,
    ROT_SP       = 3'b111
  } ocw2_cmd_e;

  // Distance from the highest-priority level; smaller rank means higher priority.
  function automatic logic [2:0] pri_rank(input logic [2:0] level, input logic [2:0] lowest);
    return level - lowest - 3'd1;
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// Picks the highest-priority set bit of an 8-bit vector under a rotating
// priority order whose highest level is lowest_pri+1.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] vec,
  input  logic [2:0] lowest_pri,
  output logic       valid,
  output logic [2:0] level
);

  logic [2:0] idx;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    level = 3'd0;
    idx   = 3'd0;
    // Scan from lowest to highest priority so the last hit is the winner.
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      idx = lowest_pri + 3'd1 + 3'(i);
      if (vec[idx]) begin
        valid = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// IRR/ISR ownership, fully-nested priority, OCW2 commands and the 8086-mode
// two-pulse INTA sequence that places the vector on the data bus.
module interrupt_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic       INTA,
  input  logic [7:0] ICW1,
  input  logic [7:0] ICW2,
  input  logic [7:0] ICW4,
  input  logic [7:0] OCW1,
  input  logic [7:0] OCW2,
  input  logic [3:0] ICWFlags,
  input  logic       initStrobe,
  input  logic       ocw2Strobe,
  output logic       INT,
  output logic [7:0] dataOut,
  output logic       dataOutEnable,
  output logic [7:0] irrOut,
  output logic [7:0] isrOut
);

  seq_state_e state_q, state_d;
  logic [7:0] irr_q, irr_d, isr_q, isr_d, ir_prev_q, ir_prev_d;
  logic [7:0] data_out_q, data_out_d;
  logic [2:0] lowest_pri_q, lowest_pri_d, grant_q, grant_d;
  logic       grant_valid_q, grant_valid_d, inta_prev_q, inta_prev_d;
  logic       int_q, int_d, data_oe_q, data_oe_d, rot_aeoi_q, rot_aeoi_d;

  logic       req_valid, isr_valid, pending, initialized, inta_fall, inta_rise;
  logic [2:0] req_level, isr_level;
  logic [7:0] isr_set, isr_clr;
  logic       unused_cfg_bits;

  assign unused_cfg_bits = ^{ICW1[7:4], ICW1[2:0], ICW2[2:0], ICW4[7:2], ICW4[0], OCW2[4:3]};

  priority_resolver u_req_res (
    .vec        (irr_q & ~OCW1),
    .lowest_pri (lowest_pri_q),
    .valid      (req_valid),
    .level      (req_level)
  );

  priority_resolver u_isr_res (
    .vec        (isr_q),
    .lowest_pri (lowest_pri_q),
    .valid      (isr_valid),
    .level      (isr_level)
  );

  assign initialized = (ICWFlags == 4'b1111);
  assign inta_fall   = inta_prev_q & ~INTA;
  assign inta_rise   = ~inta_prev_q & INTA;
  assign pending     = req_valid &&
                       (!isr_valid || pri_rank(req_level, lowest_pri_q) < pri_rank(isr_level, lowest_pri_q));

  always_comb begin
    state_d       = state_q;
    lowest_pri_d  = lowest_pri_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    data_out_d    = data_out_q;
    data_oe_d     = data_oe_q;
    rot_aeoi_d    = rot_aeoi_q;
    ir_prev_d     = IR;
    inta_prev_d   = INTA;
    isr_set       = '0;
    isr_clr       = '0;
    int_d         = pending & initialized & (state_q == IDLE);
    irr_d         = ICW1[LTIM_BIT] ? IR : ((irr_q | (IR & ~ir_prev_q)) & IR);

    if (ocw2Strobe) begin
      case (ocw2_cmd_e'(OCW2[7:5]))
        EOI_NS:       if (isr_valid) isr_clr[isr_level] = 1'b1;
        EOI_SP:       isr_clr[OCW2[2:0]] = 1'b1;
        ROT_NS: begin
          if (isr_valid) begin
            isr_clr[isr_level] = 1'b1;
            lowest_pri_d       = isr_level;
          end
        end
        ROT_SP: begin
          isr_clr[OCW2[2:0]] = 1'b1;
          lowest_pri_d       = OCW2[2:0];
        end
        SET_PRI:      lowest_pri_d = OCW2[2:0];
        ROT_AEOI_SET: rot_aeoi_d = 1'b1;
        ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
        default:      ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (inta_fall) begin
          state_d       = ACK1;
          int_d         = 1'b0;
          grant_valid_d = initialized & req_valid;
          grant_d       = grant_valid_d ? req_level : 3'd7;
          if (grant_valid_d) begin
            isr_set[req_level] = 1'b1;
            irr_d[req_level]   = 1'b0;
          end
        end
      end
      ACK1:  if (inta_rise) state_d = WAIT2;
      WAIT2: begin
        if (inta_fall) begin
          state_d    = ACK2;
          data_out_d = {ICW2[7:3], grant_q};
          data_oe_d  = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
          if (ICW4[AEOI_BIT] && grant_valid_q) begin
            isr_clr[grant_q] = 1'b1;
            if (rot_aeoi_q) lowest_pri_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle acknowledge set beats any EOI clear of that bit.
    isr_d = (isr_q & ~isr_clr) | isr_set;

    if (initStrobe) begin
      state_d       = IDLE;
      irr_d         = '0;
      isr_d         = '0;
      lowest_pri_d  = 3'd7;
      grant_d       = 3'd0;
      grant_valid_d = 1'b0;
      data_out_d    = '0;
      data_oe_d     = 1'b0;
      rot_aeoi_d    = 1'b0;
      ir_prev_d     = '0;
      inta_prev_d   = 1'b1;
      int_d         = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      irr_q         <= '0;
      isr_q         <= '0;
      lowest_pri_q  <= 3'd7;
      grant_q       <= 3'd0;
      grant_valid_q <= 1'b0;
      data_out_q    <= '0;
      data_oe_q     <= 1'b0;
      rot_aeoi_q    <= 1'b0;
      ir_prev_q     <= '0;
      inta_prev_q   <= 1'b1;
      int_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      irr_q         <= irr_d;
      isr_q         <= isr_d;
      lowest_pri_q  <= lowest_pri_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      data_out_q    <= data_out_d;
      data_oe_q     <= data_oe_d;
      rot_aeoi_q    <= rot_aeoi_d;
      ir_prev_q     <= ir_prev_d;
      inta_prev_q   <= inta_prev_d;
      int_q         <= int_d;
    end
  end

  assign INT           = int_q;
  assign dataOut       = data_out_q;
  assign dataOutEnable = data_oe_q;
  assign irrOut        = irr_q;
  assign isrOut        = isr_q;

endmodule
